retospect_cfg_loader: RTL



---
 rtl/retospect_cfg_pkg.sv | 25 ++
 rtl/retospect_rb_packer.sv | 59 +++++
 rtl/retospect_cfg_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/retospect_cfg_pkg.sv
`timescale 1ns/1ps
// retospect_cfg_pkg: shared types and chain geometry for the configuration loader.
// Provides the loader state enum, per-cell bit counts and the chain length helper.
package retospect_cfg_pkg;

  localparam int unsigned CLOCKBOX_BITS = 48;
  localparam int unsigned CNB_BITS      = 21;
  localparam int unsigned X_MAX         = 5;
  localparam int unsigned Y_MAX         = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    ARM   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Total scan bits: clockbox followed by x_max*y_max cnb cells.
  function automatic int unsigned chain_len(input int unsigned x_max,
                                            input int unsigned y_max);
    return CLOCKBOX_BITS + CNB_BITS * x_max * y_max;
  endfunction

endpackage

// File: rtl/retospect_rb_packer.sv
`timescale 1ns/1ps
// retospect_rb_packer: serial-in, LSB-first byte packer with a one-cycle strobe.
// Ports: clk/reset (sync, active-high); clear drops a partial group;
//        bit_valid/bit_in deliver one bit; last closes a short group;
//        rb_data/rb_valid present each completed group (unused upper bits 0).
module retospect_rb_packer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         bit_valid,
  input  logic         bit_in,
  input  logic         last,
  output logic [W-1:0] rb_data,
  output logic         rb_valid
);

  localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     acc, acc_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             flush_c;

  // Accumulate bits; the first bit of a group overwrites stale upper bits.
  always_comb begin
    acc_nxt = acc;
    idx_nxt = idx;
    flush_c = 1'b0;
    if (clear) begin
      acc_nxt = '0;
      idx_nxt = '0;
    end else if (bit_valid) begin
      if (idx == '0) acc_nxt = W'(bit_in);
      else           acc_nxt = acc | (W'(bit_in) << idx);
      if (last || (idx == IDX_W'(W - 1))) begin
        flush_c = 1'b1;
        idx_nxt = '0;
      end else begin
        idx_nxt = idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      idx      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      acc      <= acc_nxt;
      idx      <= idx_nxt;
      rb_valid <= flush_c;
      if (flush_c) rb_data <= acc_nxt;
    end
  end

endmodule

// File: rtl/retospect_cfg_loader.sv
`timescale 1ns/1ps
// retospect_cfg_loader: owns the configuration scan chain (clockbox + cnb cells).
// Accepts bytes on in_data/in_valid/in_ready, shifts them LSB-first onto
// chain_bs_in with chain_en, captures chain_bs_out as readback bytes
// (rb_data/rb_valid), and pulses chain_reset_nn once a full CHAIN_LEN load ends.
// start begins a load from IDLE/DONE; abort cancels a load in progress.
// busy covers LOAD/SHIFT/ARM, done covers DONE. All outputs are registered.
module retospect_cfg_loader
  import retospect_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = chain_len(X_MAX, Y_MAX),
  parameter int unsigned CNT_W     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       chain_en,
  output logic       chain_bs_in,
  input  logic       chain_bs_out,
  output logic       chain_reset_nn,
  output logic       busy,
  output logic       done,
  output logic [7:0] rb_data,
  output logic       rb_valid
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NB_W   = 4;
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

  state_t           state, state_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [CNT_W-1:0] bits_done, bits_done_nxt;
  logic [NB_W-1:0]  nb, nb_nxt;
  logic [CNT_W-1:0] remaining_c;
  logic [NB_W-1:0]  nb_load_c;
  logic             rb_bit_valid_c;
  logic             rb_last_c;
  logic             rb_clear_c;

  // Bits still owed to the chain; caps the last byte at CHAIN_LEN%8 bits.
  assign remaining_c = LEN_C - bits_done;
  assign nb_load_c   = (remaining_c >= CNT_W'(BYTE_W)) ? NB_W'(BYTE_W)
                                                        : NB_W'(remaining_c);

  // Next-state and datapath; abort wins over in_valid and shift completion.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    bits_done_nxt  = bits_done;
    nb_nxt         = nb;
    rb_bit_valid_c = 1'b0;
    rb_last_c      = 1'b0;
    rb_clear_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = LOAD;
          bits_done_nxt = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt  = IDLE;
          rb_clear_c = 1'b1;
        end else if (in_valid && in_ready) begin
          shreg_nxt = in_data;
          nb_nxt    = nb_load_c;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt  = IDLE;
          rb_clear_c = 1'b1;
        end else begin
          shreg_nxt      = {1'b0, shreg[7:1]};
          bits_done_nxt  = bits_done + CNT_W'(1);
          nb_nxt         = nb - NB_W'(1);
          rb_bit_valid_c = 1'b1;
          if (nb == NB_W'(1)) begin
            rb_last_c = 1'b1;
            state_nxt = (bits_done_nxt == LEN_C) ? ARM : LOAD;
          end
        end
      end
      ARM: begin
        state_nxt = abort ? IDLE : DONE;
      end
      DONE: begin
        if (start) begin
          state_nxt     = LOAD;
          bits_done_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      shreg          <= '0;
      bits_done      <= '0;
      nb             <= '0;
      in_ready       <= 1'b0;
      chain_en       <= 1'b0;
      chain_bs_in    <= 1'b0;
      chain_reset_nn <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      shreg          <= shreg_nxt;
      bits_done      <= bits_done_nxt;
      nb             <= nb_nxt;
      in_ready       <= (state_nxt == LOAD);
      chain_en       <= (state_nxt == SHIFT);
      chain_bs_in    <= (state_nxt == SHIFT) && shreg_nxt[0];
      chain_reset_nn <= (state_nxt == ARM);
      busy           <= (state_nxt == LOAD) || (state_nxt == SHIFT) || (state_nxt == ARM);
      done           <= (state_nxt == DONE);
    end
  end

  // Readback bits are the pre-edge far-end values, grouped per loaded byte.
  retospect_rb_packer #(.W(8)) u_rb_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (rb_clear_c),
    .bit_valid (rb_bit_valid_c),
    .bit_in    (chain_bs_out),
    .last      (rb_last_c),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid)
  );

endmodule
